// File: rtl/onehot_pulse_decoder_if.sv
// Index handshake and one-hot strobe bundle for onehot_pulse_decoder.
// The master drives the index; the slave (the decoder) drives ready and the strobes.
interface onehot_pulse_decoder_if #(
    parameter int IDX_W = 3,
    parameter int N_OUT = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic [N_OUT-1:0] out_onehot;
    logic             out_active;
    logic             done;
    logic             err;

    modport master (
        output in_valid,
        output in_idx,
        input  in_ready,
        input  out_onehot,
        input  out_active,
        input  done,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in_idx,
        output in_ready,
        output out_onehot,
        output out_active,
        output done,
        output err
    );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Binary index -> timed one-hot strobe with a forced all-zero guard gap.
// Optional one-entry pending register enabled by `define ONEHOT_PULSE_DECODER_QUEUE_EN.
module onehot_pulse_decoder #(
    parameter int IDX_W    = 3,
    parameter int N_OUT    = 8,
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_pulse_decoder_if.slave  bus
);
    localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [31:0]      N_OUT_U   = N_OUT;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_OUT-1:0] onehot, onehot_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_q_nxt;
    logic             err_nxt;
    logic             accept;
    logic             idx_ok;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < N_OUT_U;
    endfunction

    function automatic logic [N_OUT-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [N_OUT-1:0] v;
        for (int i = 0; i < N_OUT; i++) begin
            v[i] = (32'(idx) == 32'(i));
        end
        return v;
    endfunction

`ifdef ONEHOT_PULSE_DECODER_QUEUE_EN
    logic             pend_valid, pend_valid_nxt;
    logic [IDX_W-1:0] pend_idx, pend_idx_nxt;
    logic             err_defer, err_defer_nxt;
    logic             period_end;

    assign bus.in_ready = !pend_valid;
    assign period_end   = ((state == HOLD) && (cnt == '0) && (GAP_CYC == 0)) ||
                          ((state == GAP) && (cnt == '0));
`else
    assign bus.in_ready = (state == IDLE);
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign idx_ok = in_range(bus.in_idx);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        onehot_nxt = onehot;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (idx_ok) begin
                        state_nxt  = HOLD;
                        cnt_nxt    = HOLD_LOAD;
                        onehot_nxt = decode(bus.in_idx);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    onehot_nxt = '0;
                    done_nxt   = 1'b1;
                    if (GAP_CYC > 0) begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                onehot_nxt = '0;
            end
        endcase

`ifdef ONEHOT_PULSE_DECODER_QUEUE_EN
        pend_valid_nxt = pend_valid;
        pend_idx_nxt   = pend_idx;
        // A queued index skips IDLE entirely; a fresh one arriving on the
        // drain edge with the queue empty is launched the same way.
        if (period_end && pend_valid) begin
            state_nxt      = HOLD;
            cnt_nxt        = HOLD_LOAD;
            onehot_nxt     = decode(pend_idx);
            pend_valid_nxt = 1'b0;
        end else if (accept && (state != IDLE)) begin
            if (!idx_ok) begin
                err_nxt = 1'b1;
            end else if (period_end) begin
                state_nxt  = HOLD;
                cnt_nxt    = HOLD_LOAD;
                onehot_nxt = decode(bus.in_idx);
            end else begin
                pend_valid_nxt = 1'b1;
                pend_idx_nxt   = bus.in_idx;
            end
        end
        // An err that would coincide with done slips by one cycle.
        err_q_nxt     = (err_nxt || err_defer) && !done_nxt;
        err_defer_nxt = (err_nxt || err_defer) && done_nxt;
`else
        err_q_nxt = err_nxt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            onehot <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            onehot <= onehot_nxt;
            done_q <= done_nxt;
            err_q  <= err_q_nxt;
        end
    end

`ifdef ONEHOT_PULSE_DECODER_QUEUE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            err_defer  <= 1'b0;
        end else begin
            pend_valid <= pend_valid_nxt;
            err_defer  <= err_defer_nxt;
        end
    end

    always_ff @(posedge clk) begin
        pend_idx <= pend_idx_nxt;
    end
`endif

    assign bus.out_onehot = onehot;
    assign bus.out_active = |onehot;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Randomized bench for onehot_pulse_decoder: an 8-line and a 6-line instance share
// stimulus and are scored against a timeline model of the accept/hold/gap rules.
module tb_onehot_pulse_decoder;
    localparam int IDX_W = 3;
    localparam int HOLD  = 4;
    localparam int GAP   = 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    onehot_pulse_decoder_if #(.IDX_W(IDX_W), .N_OUT(8)) bus8 ();
    onehot_pulse_decoder_if #(.IDX_W(IDX_W), .N_OUT(6)) bus6 ();

    onehot_pulse_decoder #(.IDX_W(IDX_W), .N_OUT(8), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    onehot_pulse_decoder #(.IDX_W(IDX_W), .N_OUT(6), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Model: each instance remembers the edge of its last valid accept.
    int edge_n = 0;
    int nout[2]     = '{8, 6};
    int last_acc[2] = '{-1000, -1000};
    int last_idx[2] = '{0, 0};
    bit err_exp[2]  = '{1'b0, 1'b0};
    bit acc_flag[2] = '{1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic int age(input int u);
        return edge_n - last_acc[u];
    endfunction

    function automatic logic [31:0] exp_onehot(input int u);
        if (age(u) >= 0 && age(u) < HOLD) return 32'(1) << last_idx[u];
        return 32'd0;
    endfunction

    function automatic logic exp_ready(input int u);
        return age(u) >= HOLD + GAP;
    endfunction

    task automatic step(input bit rst, input bit v, input int idx);
        logic [31:0] g_oh[2];
        logic        g_act[2], g_done[2], g_err[2], g_rdy[2];
        @(negedge clk);
        rst_n         = !rst;
        bus8.in_valid = v;
        bus6.in_valid = v;
        bus8.in_idx   = IDX_W'(idx);
        bus6.in_idx   = IDX_W'(idx);
        for (int u = 0; u < 2; u++) acc_flag[u] = !rst && v && exp_ready(u);
        @(posedge clk);
        #1;
        edge_n++;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                last_acc[u] = -1000;
                err_exp[u]  = 1'b0;
            end else begin
                err_exp[u] = acc_flag[u] && (idx >= nout[u]);
                if (acc_flag[u] && idx < nout[u]) begin
                    last_acc[u] = edge_n;
                    last_idx[u] = idx;
                end
            end
        end
        g_oh[0] = 32'(bus8.out_onehot);  g_oh[1] = 32'(bus6.out_onehot);
        g_act[0] = bus8.out_active;      g_act[1] = bus6.out_active;
        g_done[0] = bus8.done;           g_done[1] = bus6.done;
        g_err[0] = bus8.err;             g_err[1] = bus6.err;
        g_rdy[0] = bus8.in_ready;        g_rdy[1] = bus6.in_ready;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("onehot_n%0d", nout[u]), g_oh[u], exp_onehot(u));
            chk($sformatf("active_n%0d", nout[u]), 32'(g_act[u]), 32'(exp_onehot(u) != 0));
            chk($sformatf("done_n%0d", nout[u]), 32'(g_done[u]), 32'(age(u) == HOLD));
            chk($sformatf("err_n%0d", nout[u]), 32'(g_err[u]), 32'(err_exp[u]));
            chk($sformatf("ready_n%0d", nout[u]), 32'(g_rdy[u]), 32'(exp_ready(u)));
        end
    endtask

    initial begin
        int i;
        int guard;
        rst_n         = 1'b0;
        bus8.in_valid = 1'b0;
        bus6.in_valid = 1'b0;
        bus8.in_idx   = '0;
        bus6.in_idx   = '0;

        step(1, 0, 0);
        step(1, 0, 0);

        // single decode of index 5
        step(0, 1, 5);
        repeat (7) step(0, 0, 0);

        // every index, in_valid held until each is taken
        i = 0;
        guard = 0;
        while (i < 8 && guard < 200) begin
            step(0, 1, i);
            if (acc_flag[0]) i++;
            guard++;
        end
        chk("all_idx_accepted", 32'(i), 32'd8);
        repeat (8) step(0, 0, 0);

        // out-of-range indices on the 6-line instance
        step(0, 1, 6);
        step(0, 1, 7);
        repeat (8) step(0, 0, 0);

        // reset landing on the second hold cycle
        step(0, 1, 3);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);

        // reset mid-stream, then random traffic
        repeat (3) step(0, 1, 2);
        step(1, 1, 4);
        step(1, 0, 0);
        repeat (3000) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 6,
                 int'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
